// File: rtl/pl_lsu_if.sv
// Bundle of the pipeline request/response channel and the data-memory port.
// slave is the LSU's view; master is the pipeline-plus-memory side.
interface pl_lsu_if #(
  parameter int MEM_AW = 5
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_we;
  logic [31:0]       mem_rdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    output req_ready, mem_addr, mem_wdata, mem_we, resp_valid, resp_rdata, resp_err
  );

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    input  req_ready, mem_addr, mem_wdata, mem_we, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/pl_lsu.sv
// MEM-stage load/store initiator: one request at a time against a word-addressed
// synchronous-read memory, with sub-word extension and read-modify-write stores.
module pl_lsu #(
  parameter int MEM_AW = 5
) (
  input  logic    clock,
  input  logic    reset,
  pl_lsu_if.slave bus
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RD    = 3'd1;
  localparam logic [2:0] RWAIT = 3'd2;
  localparam logic [2:0] WR    = 3'd3;
  localparam logic [2:0] RESP  = 3'd4;

  logic [2:0]        state;
  logic              we_q;
  logic [1:0]        size_q;
  logic              signed_q;
  logic [1:0]        lane_q;
  logic [15:0]       wdata_q;
  logic [MEM_AW-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic              mem_we_q;
  logic              resp_valid_q;
  logic              resp_err_q;
  logic [31:0]       resp_rdata_q;

  logic              req_err;
  logic [7:0]        byte_lane;
  logic [15:0]       half_lane;
  logic [31:0]       load_val;
  logic [31:0]       merged;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^bus.req_addr[31:MEM_AW+2];

  assign req_err = (bus.req_size == 2'b11) ||
                   (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                   (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00);

  // Lane extraction for loads and lane merge for sub-word stores, both little-endian.
  always_comb begin
    byte_lane = bus.mem_rdata[{lane_q, 3'b000} +: 8];
    half_lane = bus.mem_rdata[{lane_q[1], 4'b0000} +: 16];
    case (size_q)
      2'b00:   load_val = {{24{signed_q & byte_lane[7]}}, byte_lane};
      2'b01:   load_val = {{16{signed_q & half_lane[15]}}, half_lane};
      default: load_val = bus.mem_rdata;
    endcase
    merged = bus.mem_rdata;
    if (size_q == 2'b00)
      merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    else
      merged[{lane_q[1], 4'b0000} +: 16] = wdata_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      we_q         <= 1'b0;
      size_q       <= 2'b00;
      signed_q     <= 1'b0;
      lane_q       <= 2'b00;
      wdata_q      <= 16'd0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 32'd0;
      mem_we_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'd0;
    end else begin
      mem_we_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            we_q     <= bus.req_we;
            size_q   <= bus.req_size;
            signed_q <= bus.req_signed;
            lane_q   <= bus.req_addr[1:0];
            wdata_q  <= bus.req_wdata[15:0];
            if (req_err) begin
              state        <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= 32'd0;
            end else begin
              mem_addr_q <= bus.req_addr[MEM_AW+1:2];
              if (bus.req_we && bus.req_size == 2'b10) begin
                state       <= WR;
                mem_we_q    <= 1'b1;
                mem_wdata_q <= bus.req_wdata;
              end else begin
                state <= RD;
              end
            end
          end
        end
        RD: state <= RWAIT;
        // Read data is valid here: finish a load or build the merged store word.
        RWAIT: begin
          if (we_q) begin
            state       <= WR;
            mem_we_q    <= 1'b1;
            mem_wdata_q <= merged;
          end else begin
            state        <= RESP;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= load_val;
          end
        end
        WR: begin
          state        <= RESP;
          resp_valid_q <= 1'b1;
          resp_rdata_q <= 32'd0;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
endmodule

// File: tb/tb_pl_lsu.sv
// Directed bench for pl_lsu against a small synchronous-read memory model.
module tb_pl_lsu;
  logic clock;
  logic reset;
  int   test_count;
  int   fail_count;
  logic [31:0] mem [0:31];

  pl_lsu_if #(.MEM_AW(5)) bus ();

  pl_lsu #(.MEM_AW(5)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  // Word-addressed memory: read data appears the cycle after the address.
  always @(posedge clock) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    test_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic we, input logic [1:0] size, input logic sgn,
                                input logic [31:0] addr, input logic [31:0] wdata);
    bus.req_we     = we;
    bus.req_size   = size;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
  endtask

  // Issues one request and follows it to its response, tracking writes and ready.
  task automatic run_req(input string tag, input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata, input int exp_lat,
                         input logic exp_err, input logic [31:0] exp_rdata, input int exp_writes,
                         input logic [31:0] exp_waddr, input logic [31:0] exp_wword);
    int lat;
    int writes;
    logic [31:0] waddr;
    logic [31:0] wword;
    logic ready_high;
    logic got;
    lat = 0; writes = 0; waddr = 0; wword = 0; ready_high = 0; got = 0;
    check_output({tag, " ready before"}, 32'(bus.req_ready), 32'd1);
    apply_stimulus(we, size, sgn, addr, wdata);
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    for (int n = 1; n <= 12 && !got; n++) begin
      if (bus.mem_we) begin
        writes++;
        waddr = 32'(bus.mem_addr);
        wword = bus.mem_wdata;
      end
      if (bus.req_ready) ready_high = 1'b1;
      if (bus.resp_valid) begin
        got = 1'b1;
        lat = n;
        check_output({tag, " err"}, 32'(bus.resp_err), 32'(exp_err));
        check_output({tag, " rdata"}, bus.resp_rdata, exp_rdata);
      end else begin
        tick();
      end
    end
    check_output({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check_output({tag, " writes"}, 32'(writes), 32'(exp_writes));
    if (exp_writes > 0) begin
      check_output({tag, " waddr"}, waddr, exp_waddr);
      check_output({tag, " wdata"}, wword, exp_wword);
    end
    check_output({tag, " ready busy"}, 32'(ready_high), 32'd0);
    tick();
    check_output({tag, " resp pulse"}, 32'(bus.resp_valid), 32'd0);
    check_output({tag, " ready after"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    int acc;
    int rsp;
    int low;
    int stray;
    int acc_cyc [3];
    int rsp_cyc [3];
    clock = 1'b0;
    test_count = 0;
    fail_count = 0;
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;

    // Reset with a request pending: reset wins and nothing is accepted.
    reset = 1'b1;
    bus.req_valid = 1'b1;
    apply_stimulus(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'h1234_5678);
    tick();
    tick();
    check_output("rst ready", 32'(bus.req_ready), 32'd1);
    check_output("rst mem_we", 32'(bus.mem_we), 32'd0);
    check_output("rst mem_addr", 32'(bus.mem_addr), 32'd0);
    check_output("rst mem_wdata", bus.mem_wdata, 32'd0);
    check_output("rst resp_valid", 32'(bus.resp_valid), 32'd0);
    check_output("rst resp_rdata", bus.resp_rdata, 32'd0);
    check_output("rst resp_err", 32'(bus.resp_err), 32'd0);
    bus.req_valid = 1'b0;
    reset = 1'b0;
    tick();
    check_output("rst no write", mem[4], 32'd0);

    run_req("sw 08", 1'b1, 2'b10, 1'b0, 32'h08, 32'hDEAD_BEEF, 2, 1'b0, 32'd0, 1, 32'd2, 32'hDEAD_BEEF);
    run_req("lw 08", 1'b0, 2'b10, 1'b0, 32'h08, 32'd0, 3, 1'b0, 32'hDEAD_BEEF, 0, 32'd0, 32'd0);
    run_req("sw 08 b", 1'b1, 2'b10, 1'b0, 32'h08, 32'h80FF_7F01, 2, 1'b0, 32'd0, 1, 32'd2, 32'h80FF_7F01);
    run_req("lb 0b", 1'b0, 2'b00, 1'b1, 32'h0B, 32'd0, 3, 1'b0, 32'hFFFF_FF80, 0, 32'd0, 32'd0);
    run_req("lbu 0b", 1'b0, 2'b00, 1'b0, 32'h0B, 32'd0, 3, 1'b0, 32'h0000_0080, 0, 32'd0, 32'd0);
    run_req("lb 08", 1'b0, 2'b00, 1'b1, 32'h08, 32'd0, 3, 1'b0, 32'h0000_0001, 0, 32'd0, 32'd0);
    run_req("lh 0a", 1'b0, 2'b01, 1'b1, 32'h0A, 32'd0, 3, 1'b0, 32'hFFFF_80FF, 0, 32'd0, 32'd0);
    run_req("lhu 0a", 1'b0, 2'b01, 1'b0, 32'h0A, 32'd0, 3, 1'b0, 32'h0000_80FF, 0, 32'd0, 32'd0);

    run_req("sw 10", 1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344, 2, 1'b0, 32'd0, 1, 32'd4, 32'h1122_3344);
    run_req("sb 11", 1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFF_FFAA, 4, 1'b0, 32'd0, 1, 32'd4, 32'h1122_AA44);
    run_req("sh 12", 1'b1, 2'b01, 1'b0, 32'h12, 32'h1234_BEEF, 4, 1'b0, 32'd0, 1, 32'd4, 32'hBEEF_AA44);
    run_req("lw 10", 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 3, 1'b0, 32'hBEEF_AA44, 0, 32'd0, 32'd0);

    run_req("err lw 0d", 1'b0, 2'b10, 1'b0, 32'h0D, 32'd0, 1, 1'b1, 32'd0, 0, 32'd0, 32'd0);
    run_req("lw 10 b", 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 3, 1'b0, 32'hBEEF_AA44, 0, 32'd0, 32'd0);
    run_req("err sh 03", 1'b1, 2'b01, 1'b0, 32'h03, 32'hFFFF_FFFF, 1, 1'b1, 32'd0, 0, 32'd0, 32'd0);
    run_req("err size3", 1'b1, 2'b11, 1'b0, 32'h00, 32'hFFFF_FFFF, 1, 1'b1, 32'd0, 0, 32'd0, 32'd0);
    run_req("lw 10 c", 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 3, 1'b0, 32'hBEEF_AA44, 0, 32'd0, 32'd0);

    // Abort a byte store during RWAIT: no write and no response may follow.
    stray = 0;
    apply_stimulus(1'b1, 2'b00, 1'b0, 32'h10, 32'h0000_0055);
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    if (bus.mem_we) stray++;
    tick();
    if (bus.mem_we) stray++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_output("abort ready", 32'(bus.req_ready), 32'd1);
    check_output("abort mem_addr", 32'(bus.mem_addr), 32'd0);
    check_output("abort resp_rdata", bus.resp_rdata, 32'd0);
    for (int i = 0; i < 5; i++) begin
      if (bus.mem_we || bus.resp_valid) stray++;
      tick();
    end
    check_output("abort stray", 32'(stray), 32'd0);
    check_output("abort mem word", mem[4], 32'hBEEF_AA44);
    run_req("lw after abort", 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 3, 1'b0, 32'hBEEF_AA44, 0, 32'd0, 32'd0);

    // req_valid held high: three loads accepted four cycles apart.
    acc = 0; rsp = 0; low = 0;
    for (int i = 0; i < 3; i++) begin
      acc_cyc[i] = -1;
      rsp_cyc[i] = -1;
    end
    apply_stimulus(1'b0, 2'b10, 1'b0, 32'h08, 32'd0);
    bus.req_valid = 1'b1;
    for (int i = 0; i < 15; i++) begin
      if (bus.req_ready && bus.req_valid) begin
        if (acc < 3) acc_cyc[acc] = i;
        acc++;
      end
      if (!bus.req_ready) low++;
      if (bus.resp_valid) begin
        if (rsp < 3) rsp_cyc[rsp] = i;
        rsp++;
        check_output("hold rdata", bus.resp_rdata, 32'h80FF_7F01);
      end
      tick();
      if (acc >= 3) bus.req_valid = 1'b0;
    end
    check_output("hold accepts", 32'(acc), 32'd3);
    check_output("hold responses", 32'(rsp), 32'd3);
    check_output("hold accept 1", 32'(acc_cyc[1]), 32'd4);
    check_output("hold accept 2", 32'(acc_cyc[2]), 32'd8);
    check_output("hold resp 0", 32'(rsp_cyc[0]), 32'd3);
    check_output("hold resp 2", 32'(rsp_cyc[2]), 32'd11);
    check_output("hold ready low", 32'(low), 32'd9);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule

// File: doc/pl_lsu.md
Name: pl_lsu

Overview:
- Load/store initiator for the pipelined CPU's MEM stage; the requester side of the data-memory interface.
- Accepts one load or store request at a time from the pipeline.
- Drives word-addressed, synchronous-read data memory: address, write data and write enable.
- Handles byte/halfword/word sizes: sign/zero extension on loads, read-modify-write for sub-word stores. Returns a one-cycle response pulse; the pipeline stalls while req_ready=0.

Parameters:
MEM_AW, 5, word-address width driven to memory (memory indexed by byte address bits [MEM_AW+1:2]; higher bits ignored)

Ports:
clock  input  1  single system clock, all state on rising edge
reset  input  1  synchronous, active-high
req_valid  input  1  request present
req_ready  output  1  block idle, can accept request this cycle
req_we  input  1  1=store, 0=load
req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal
req_signed  input  1  loads: 1=sign-extend, 0=zero-extend
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
mem_addr  output  MEM_AW  word address to data memory
mem_wdata  output  32  write data to data memory
mem_we  output  1  write enable to data memory
mem_rdata  input  32  memory read data, valid the cycle after mem_addr is presented
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  32  load result, extended; 0 for stores and errors
resp_err  output  1  misaligned or illegal-size request, qualified by resp_valid

Behaviour:
- Reset: state IDLE; req_ready=1; mem_we=0; mem_addr=0; mem_wdata=0; resp_valid=0; resp_rdata=0; resp_err=0. All internal request registers are cleared.
- States: IDLE, RD, RWAIT, WR, RESP. req_ready=1 only in IDLE.
- Accept happens on a clock edge in IDLE with req_valid=1. The request is captured into registers. Memory outputs are driven only from registers, never combinationally from req_*.
- Error check at accept:
  - size 11 is an error.
  - halfword with addr[0]=1 is an error.
  - word with addr[1:0]!=0 is an error.
  - On error: go directly to RESP with resp_err=1 and resp_rdata=0. mem_we is never asserted.
- Next state from IDLE: word store -> WR; any load or sub-word store -> RD.
- RD: mem_addr=addr[MEM_AW+1:2], mem_we=0. Next state RWAIT.
- RWAIT: mem_rdata valid.
  - Load: register the extracted/extended lane into resp_rdata. Next state RESP.
  - Sub-word store: register the merged word into the write buffer. Next state WR.
- Lane selection is little-endian:
  - byte lane = addr[1:0], bits [8*k+7:8*k].
  - half lane = addr[1], bits [16*h+15:16*h].
  - Store merge replaces only the selected lane with req_wdata[7:0] or [15:0]; other bytes keep the mem_rdata value.
- WR: mem_we=1 for exactly one cycle. mem_addr = word address. mem_wdata = req_wdata (word store) or the merged word. Next state RESP.
- RESP: resp_valid=1 for exactly one cycle, resp_err as determined. Next state IDLE. req_ready returns to 1 in the following cycle.
- Latency, counted in cycles after the accept edge, to the resp_valid cycle:
  - word store: 2 (WR, RESP)
  - load: 3 (RD, RWAIT, RESP)
  - sub-word store: 4 (RD, RWAIT, WR, RESP)
  - error: 1 (RESP)
- Back-to-back: no request is accepted during RESP. The earliest next accept is the first IDLE cycle; the minimum issue interval is latency+1.
- req_* are ignored when req_ready=0. Holding req_valid high across a response does not cause a double accept, because ready drops on accept.
- mem_we is 0 in every state except WR.
- mem_addr holds its last value in IDLE.
- resp_rdata holds its value until the next RESP. For stores and errors it is forced to 0 in RESP.
- Reset mid-operation: the next state is IDLE and all outputs return to reset values at that edge.
  - A WR cycle already sampled by memory stays written.
  - A sub-word store aborted in RD/RWAIT produces no write.
  - No resp_valid is issued for the aborted request.
- Simultaneous reset and req_valid: reset wins, no accept.

Test Plan:
- Word store then load: store addr=0x08, data=0xDEADBEEF -> WR cycle: mem_addr=2, mem_we=1, mem_wdata=0xDEADBEEF; resp_valid 2 cycles after accept. Then load word 0x08 -> resp_rdata=0xDEADBEEF, 3 cycles after accept.
- Byte loads, memory word 2 = 0x80FF7F01:
  - lb addr 0x0B (signed) -> 0xFFFFFF80.
  - lbu addr 0x0B -> 0x00000080.
  - lb addr 0x08 -> 0x00000001.
  - lh addr 0x0A -> 0xFFFF80FF.
  - lhu addr 0x0A -> 0x000080FF.
- Sub-word stores on word 0x11223344 at addr 0x10:
  - sb 0xAA to 0x11 -> single mem_we cycle writes 0x1122AA44; resp 4 cycles after accept.
  - sh 0xBEEF to 0x12 -> writes 0xBEEFAA44.
- Errors, each giving resp_err=1, resp_rdata=0, mem_we never asserted, resp 1 cycle after accept:
  - lw addr 0x0D.
  - sh addr 0x03.
  - size=11.
- Reset in RWAIT of a sb: no mem_we; state IDLE with req_ready=1 the cycle after reset; memory word unchanged. A following load returns the original value.
- req_valid held high for 3 consecutive loads -> exactly 3 accepts, each separated by 4 cycles. resp_valid is a 1-cycle pulse per load; req_ready=0 from accept through RESP.
